// File: rtl/demux_latch.sv
// demux_latch: routes a synchronised switch word into one of NUM_LANES registered
// lanes, selected by a synchronised key, on each debounced push-button press.
module demux_latch #(
  parameter int unsigned NUM_LANES    = 4,
  parameter int unsigned SEL_W        = 2,
  parameter int unsigned DATA_W       = 2,
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          strobe,
  input  logic                          clr,
  input  logic [SEL_W-1:0]              sel,
  input  logic [DATA_W-1:0]             din,
  output logic [NUM_LANES*DATA_W-1:0]   lane_out,
  output logic [NUM_LANES-1:0]          lane_vld,
  output logic                          wr_ack,
  output logic [7:0]                    wr_cnt
);

  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned WRCNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  // Two-flop synchroniser stages for all board inputs
  logic [1:0]        strobe_sync;
  logic [1:0]        clr_sync;
  logic [SEL_W-1:0]  sel_meta;
  logic [SEL_W-1:0]  sel_s;
  logic [DATA_W-1:0] din_meta;
  logic [DATA_W-1:0] din_s;

  logic strobe_s;
  logic clr_s;

  // Debounce state
  logic [CNT_W-1:0] deb_cnt;
  logic             deb;
  logic             deb_q;
  logic             wr_c;

  // FSM state
  state_t state_q;
  state_t state_d;
  logic   write_c;

  // Lane storage, packed so lane i sits at [i*DATA_W +: DATA_W]
  logic [NUM_LANES-1:0][DATA_W-1:0] lane_q;

  assign strobe_s = strobe_sync[1];
  assign clr_s    = clr_sync[1];
  assign lane_out = lane_q;

  // Synchronise asynchronous board inputs into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_sync <= '0;
      clr_sync    <= '0;
      sel_meta    <= '0;
      sel_s       <= '0;
      din_meta    <= '0;
      din_s       <= '0;
    end else begin
      strobe_sync <= {strobe_sync[0], strobe};
      clr_sync    <= {clr_sync[0], clr};
      sel_meta    <= sel;
      sel_s       <= sel_meta;
      din_meta    <= din;
      din_s       <= din_meta;
    end
  end

  // Debounce: deb follows the synced strobe only after DEBOUNCE_CYC stable cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt <= '0;
      deb     <= 1'b0;
    end else if (strobe_s == deb) begin
      deb_cnt <= '0;
    end else if (deb_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
      deb     <= strobe_s;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + CNT_W'(1);
    end
  end

  // Delayed debounced level for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q <= 1'b0;
    end else begin
      deb_q <= deb;
    end
  end

  assign wr_c = deb & ~deb_q;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: one honoured write per press; ARMED waits for the button to be released
  always_comb begin
    state_d = state_q;
    write_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_c) begin
          state_d = ARMED;
          write_c = 1'b1;
        end
      end
      ARMED: begin
        if (!deb) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Lane update; a synced clear wins over a same-cycle write and swallows it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q   <= '0;
      lane_vld <= '0;
      wr_ack   <= 1'b0;
      wr_cnt   <= '0;
    end else begin
      wr_ack <= 1'b0;
      if (clr_s) begin
        lane_q   <= '0;
        lane_vld <= '0;
      end else if (write_c) begin
        lane_q[sel_s]   <= din_s;
        lane_vld[sel_s] <= 1'b1;
        wr_cnt          <= wr_cnt + WRCNT_W'(1);
        wr_ack          <= 1'b1;
      end
    end
  end

endmodule
